kmx_scanner: RTL and testbench
==============================

// Module: kmx_scanner
// PURPOSE
//  Parametrised key-matrix scanner; successor to the fixed 3x4 scanner.
//  - Drives COLS one-hot column strobes with a blanking gap between columns.
//  - Samples ROWS row inputs per column and debounces each key over whole scan frames.
//  - Publishes debounced state plus a buffered press/release event stream (valid/ready) for the PWM/UI control logic.
// PARAMETERS
//  COLS           3      number of columns driven (>=2)
//  ROWS           4      number of row inputs (>=1)
//  SCAN_CNT       25000  clk cycles per column strobe (1 ms @ 25 MHz)
//  BLANK_CNT      250    clk cycles of all-off blanking after each strobe; must be >= ROWS+1
//  DEBOUNCE       4      consecutive differing frames required to change a key state (>=1)
//  FIFO_DEPTH     8      event FIFO entries (power of two, >=2)
//  ROW_ACTIVE_LOW 0      1: row input 0 means pressed (inverted after synchroniser)
// PORTS
//  clk          in   1                  system clock, 25 MHz
//  rst_n        in   1                  asynchronous active-low reset
//  scan_en      in   1                  1: run scanning; 0: hold in blanking
//  col_data     in   ROWS               raw row inputs (asynchronous)
//  col_power    out  COLS               one-hot column strobe, 0 during blanking
//  data         out  COLS*ROWS          debounced key state, bits [c*ROWS +: ROWS] = column c
//  evt_valid    out  1                  event available
//  evt_ready    in   1                  consumer accepts event
//  evt_code     out  clog2(COLS*ROWS)   key index c*ROWS+r
//  evt_press    out  1                  1 press, 0 release
//  evt_overflow out  1                  sticky: event dropped on full FIFO
//  ovf_clr      in   1                  clears evt_overflow
// BEHAVIOUR
//  - Reset (async, immediate): col_power=0, data=0, evt_valid=0, evt_overflow=0; all counters, debounce and FIFO state cleared.
//  - After reset release: sequencer starts in BLANK (BLANK_CNT cycles), then SCAN col0.
//  - Sequencer cycle: SCAN c (SCAN_CNT cycles) -> BLANK (BLANK_CNT cycles) -> SCAN (c+1) mod COLS.
//  - col_power registered: exactly one bit high for exactly SCAN_CNT cycles per SCAN phase.
//  - scan_en=0: sequencer forced to BLANK, counter cleared, col_power=0; data and FIFO untouched.
//    On scan_en rising, restart with a full BLANK, then col0.
//  - Rows: 2-FF synchroniser, then polarity fix per ROW_ACTIVE_LOW.
//    Sample taken on the last SCAN cycle of column c (cycle S).
//  - Debounce, per key (c,r), evaluated at S+1 from the sample taken at cycle S:
//    - raw==state: cnt<=0.
//    - raw!=state and cnt==DEBOUNCE-1: state<=raw, cnt<=0, mark key changed.
//    - otherwise: cnt++.
//    - DEBOUNCE=1 gives an immediate update.
//  - data changes at S+1.
//  - Event serialiser: changed mask latched at S+1. From S+2 it pushes one event per cycle, lowest row first; it finishes inside BLANK (BLANK_CNT>=ROWS+1).
//  - FIFO: show-ahead; a pushed event is visible on evt_valid the cycle after the push.
//    - Pop on evt_valid && evt_ready.
//    - evt_code/evt_press held stable while evt_valid && !evt_ready.
//    - Push while full with no pop: event dropped, evt_overflow<=1, key state still updates.
//    - Push while full with a pop in the same cycle: accepted, no drop.
//  - evt_overflow: a set condition and ovf_clr in the same cycle -> stays 1.
//  - Counter widths: clog2(max(SCAN_CNT,BLANK_CNT)), clog2(COLS), clog2(DEBOUNCE) (min 1 bit).
//    Column index wraps COLS-1 -> 0.
//  - Elaboration error if BLANK_CNT < ROWS+1, or FIFO_DEPTH is not a power of two.
// STRUCTURE
//  - kmx_pkg:
//    - phase typedef {PH_BLANK, PH_SCAN}
//    - clog2 function
//    - event struct {code, press}
//  - kmx_evt_fifo: sub-module, sync show-ahead FIFO (WIDTH, DEPTH), full/empty, push/pop. Instantiated once.
//  - Top level holds sequencer, synchroniser, debounce array, serialiser, overflow flag.
// TESTING (bench params: SCAN_CNT=20, BLANK_CNT=6, DEBOUNCE=2, defaults otherwise)
//  1. Idle, scan_en=1 -> col_power 000(6) 001(20) 000(6) 010(20) 000(6) 100(20), then repeats; counts exact; data=0.
//  2. Row2 high during col1 strobes, held 2 frames -> data=12'h040; one event code=6 press=1. Remove -> code=6 press=0, data=0.
//  3. Row0 high for a single col0 frame only -> data stays 0, no event.
//  4. Rows 0 and 3 high in col0 for 2 frames -> events code 0 then code 3, consecutive cycles; data=12'h009.
//  5. evt_ready=0, 9 state changes -> 8 events retained in order, evt_overflow=1. ovf_clr pulse -> 0. Drain with ready=1 -> 8 pops.
//  6. rst_n low mid-SCAN -> col_power=0 and evt_valid=0 without a clock edge; after release, BLANK 6 cycles, then col0.
//     Also scan_en=0 mid-scan -> col_power=0 next cycle.

Source files
------------

// File: rtl/kmx_pkg.sv
// kmx_pkg: shared types and helpers for the key-matrix scanner.
//   kmx_phase_t : sequencer phase (blanking gap or column strobe)
//   kmx_evt_t   : one press/release event as stored in the event FIFO
//   clog2       : ceiling log2, usable in parameter/port width expressions
package kmx_pkg;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SCAN  = 1'b1
    } kmx_phase_t;

    // Widest key index an event can carry; the top trims to its own width.
    localparam int KMX_CODE_MAX_W = 16;

    typedef struct packed {
        logic [KMX_CODE_MAX_W-1:0] code;
        logic                      press;
    } kmx_evt_t;

    // ceil(log2(value)); clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/kmx_evt_fifo.sv
// kmx_evt_fifo: synchronous show-ahead FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (pointers and storage cleared)
//   push, din  : write request and data; accepted when not full, or when full
//                and a pop happens in the same cycle
//   pop        : read request; ignored when empty
//   dout       : head entry, valid whenever empty is low (show-ahead)
//   full/empty : occupancy flags
module kmx_evt_fifo
    import kmx_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot being written.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/kmx_scanner.sv
// kmx_scanner: parametrised key-matrix scanner.
//   clk, rst_n   : 25 MHz clock, asynchronous active-low reset
//   scan_en      : 1 runs the column sequencer, 0 parks it in blanking
//   col_data     : raw (asynchronous) row inputs
//   col_power    : registered one-hot column strobe, all-zero while blanking
//   data         : debounced key state, column c in bits [c*ROWS +: ROWS]
//   evt_*        : buffered press/release event stream (see handshake note)
//   evt_overflow : sticky flag, an event was dropped on a full FIFO
//   ovf_clr      : clears evt_overflow (a same-cycle set wins)
//
// Event handshake: evt_valid is high while the FIFO holds an event; an event
// is consumed on any clock edge where evt_valid && evt_ready. While
// evt_valid && !evt_ready, evt_code/evt_press stay unchanged.
module kmx_scanner
    import kmx_pkg::*;
#(
    parameter int COLS           = 3,
    parameter int ROWS           = 4,
    parameter int SCAN_CNT       = 25000,
    parameter int BLANK_CNT      = 250,
    parameter int DEBOUNCE       = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int ROW_ACTIVE_LOW = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          scan_en,
    input  logic [ROWS-1:0]               col_data,
    output logic [COLS-1:0]               col_power,
    output logic [COLS*ROWS-1:0]          data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [clog2(COLS*ROWS)-1:0]   evt_code,
    output logic                          evt_press,
    output logic                          evt_overflow,
    input  logic                          ovf_clr
);

    localparam int KEYS    = COLS * ROWS;
    localparam int CNT_MAX = (SCAN_CNT > BLANK_CNT) ? SCAN_CNT : BLANK_CNT;
    localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);
    localparam int COL_W   = (clog2(COLS) < 1) ? 1 : clog2(COLS);
    localparam int DB_W    = (clog2(DEBOUNCE) < 1) ? 1 : clog2(DEBOUNCE);
    localparam int ROW_W   = (clog2(ROWS) < 1) ? 1 : clog2(ROWS);
    localparam int CODE_W  = clog2(KEYS);

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_CNT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CNT - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE - 1);
    localparam logic [ROWS-1:0]  ROW_IDLE   = (ROW_ACTIVE_LOW != 0) ? '1 : '0;

    generate
        if (BLANK_CNT < ROWS + 1) begin : g_bad_blank
            $error("kmx_scanner: BLANK_CNT must be at least ROWS+1");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("kmx_scanner: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    // ---------------- column sequencer ----------------
    kmx_phase_t       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [COLS-1:0]  col_pw_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + CNT_W'(1);
        col_d   = col_q;
        if (!scan_en) begin
            // Parked: re-enabling restarts with a full blanking gap, then col0.
            phase_d = PH_BLANK;
            cnt_d   = '0;
            col_d   = '0;
        end else if (phase_q == PH_BLANK) begin
            if (cnt_q == BLANK_LAST) begin
                phase_d = PH_SCAN;
                cnt_d   = '0;
            end
        end else if (cnt_q == SCAN_LAST) begin
            phase_d = PH_BLANK;
            cnt_d   = '0;
            col_d   = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
        end
    end

    // Strobe is registered from the next state so it tracks phase_q exactly.
    always_comb begin
        col_pw_d = '0;
        if (phase_d == PH_SCAN) begin
            col_pw_d[col_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= PH_BLANK;
            cnt_q     <= '0;
            col_q     <= '0;
            col_power <= '0;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            col_power <= col_pw_d;
        end
    end

    // ---------------- row synchroniser ----------------
    logic [ROWS-1:0] row_s1_q, row_s2_q, row_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q <= ROW_IDLE;
            row_s2_q <= ROW_IDLE;
        end else begin
            row_s1_q <= col_data;
            row_s2_q <= row_s1_q;
        end
    end

    assign row_v = (ROW_ACTIVE_LOW != 0) ? ~row_s2_q : row_s2_q;

    // ---------------- debounce array ----------------
    // The sample is the synchronised row value on the last strobe cycle; the
    // update lands on that cycle's closing edge so data changes one cycle later.
    logic            sample_now;
    logic [KEYS-1:0] state_q, state_d;
    logic [DB_W-1:0] db_q [KEYS];
    logic [DB_W-1:0] db_d [KEYS];
    logic [ROWS-1:0] chg_d;

    assign sample_now = scan_en && (phase_q == PH_SCAN) && (cnt_q == SCAN_LAST);

    always_comb begin
        int k;
        k       = 0;
        state_d = state_q;
        chg_d   = '0;
        for (int i = 0; i < KEYS; i++) begin
            db_d[i] = db_q[i];
        end
        if (sample_now) begin
            for (int r = 0; r < ROWS; r++) begin
                k = int'(col_q) * ROWS + r;
                if (row_v[r] == state_q[k]) begin
                    db_d[k] = '0;
                end else if (db_q[k] == DB_LAST) begin
                    state_d[k] = row_v[r];
                    db_d[k]    = '0;
                    chg_d[r]   = 1'b1;
                end else begin
                    db_d[k] = db_q[k] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            for (int i = 0; i < KEYS; i++) begin
                db_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < KEYS; i++) begin
                db_q[i] <= db_d[i];
            end
        end
    end

    assign data = state_q;

    // ---------------- event serialiser ----------------
    // pend_q holds the changed mask for one cycle, then it moves into
    // ser_mask_q which emits its lowest set row each cycle until empty.
    logic [ROWS-1:0]   pend_q, ser_mask_q;
    logic [COL_W-1:0]  pend_col_q, ser_col_q;
    logic [ROW_W-1:0]  ser_row;
    logic              ser_hit;
    logic [CODE_W-1:0] evt_idx;
    kmx_evt_t          evt_in, evt_out;

    always_comb begin
        ser_row = '0;
        ser_hit = 1'b0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (ser_mask_q[r]) begin
                ser_row = ROW_W'(r);
                ser_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pend_col_q <= '0;
            ser_mask_q <= '0;
            ser_col_q  <= '0;
        end else begin
            if (sample_now) begin
                pend_q     <= chg_d;
                pend_col_q <= col_q;
            end else begin
                pend_q <= '0;
            end
            if (|pend_q) begin
                ser_mask_q <= pend_q;
                ser_col_q  <= pend_col_q;
            end else if (ser_hit) begin
                ser_mask_q[ser_row] <= 1'b0;
            end
        end
    end

    assign evt_idx      = CODE_W'(int'(ser_col_q) * ROWS + int'(ser_row));
    assign evt_in.code  = KMX_CODE_MAX_W'(evt_idx);
    assign evt_in.press = state_q[evt_idx];

    // ---------------- event FIFO and overflow flag ----------------
    logic fifo_full, fifo_empty, fifo_pop, ovf_set;
    logic unused_evt_bits;

    kmx_evt_fifo #(
        .WIDTH ($bits(kmx_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ser_hit),
        .din   (evt_in),
        .pop   (fifo_pop),
        .dout  (evt_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid       = !fifo_empty;
    assign fifo_pop        = evt_valid && evt_ready;
    assign evt_code        = evt_out.code[CODE_W-1:0];
    assign evt_press       = evt_out.press;
    assign unused_evt_bits = ^evt_out.code;
    assign ovf_set         = ser_hit && fifo_full && !fifo_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_overflow <= 1'b0;
        end else if (ovf_set) begin
            evt_overflow <= 1'b1;
        end else if (ovf_clr) begin
            evt_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kmx_scanner.sv
// tb_kmx_scanner: directed bench for kmx_scanner with an event scoreboard.
module tb_kmx_scanner;

    localparam int COLS   = 3;
    localparam int ROWS   = 4;
    localparam int KEYS   = COLS * ROWS;
    localparam int CODE_W = 4;
    localparam int FRAME3 = 240;   // three scan frames (3 * 78) plus margin

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scan_en = 1'b0;
    logic evt_ready = 1'b0;
    logic ovf_clr = 1'b0;
    logic [ROWS-1:0] col_data;
    logic [COLS-1:0] col_power;
    logic [KEYS-1:0] data;
    logic evt_valid, evt_press, evt_overflow;
    logic [CODE_W-1:0] evt_code;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    kmx_scanner #(
        .COLS (3), .ROWS (4), .SCAN_CNT (20), .BLANK_CNT (6),
        .DEBOUNCE (2), .FIFO_DEPTH (8), .ROW_ACTIVE_LOW (0)
    ) dut (
        .clk (clk), .rst_n (rst_n), .scan_en (scan_en), .col_data (col_data),
        .col_power (col_power), .data (data), .evt_valid (evt_valid),
        .evt_ready (evt_ready), .evt_code (evt_code), .evt_press (evt_press),
        .evt_overflow (evt_overflow), .ovf_clr (ovf_clr)
    );

    // Key matrix model: a pressed key connects its column strobe to its row.
    logic [KEYS-1:0] keys = '0;
    always_comb begin
        col_data = '0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (keys[c*ROWS+r] && col_power[c]) col_data[r] = 1'b1;
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;
    int pop_cyc[$];
    logic [CODE_W:0] exp_q[$];   // {code, press}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_evt(input int code, input bit press);
        exp_q.push_back({CODE_W'(code), press});
    endtask

    // Monitor: compares every accepted event with the queue head, and checks
    // a stalled head against the expected head.
    initial begin
        logic [CODE_W:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && evt_valid) begin
                if (evt_ready) begin
                    n_pops++;
                    pop_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_event: got code %0d press %0d, expected none",
                                 evt_code, evt_press);
                    end else begin
                        e = exp_q.pop_front();
                        check("event", 32'({evt_code, evt_press}), 32'(e));
                    end
                end else if (exp_q.size() != 0) begin
                    check("stalled_head", 32'({evt_code, evt_press}), 32'(exp_q[0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [COLS-1:0] exp_rv [8] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    int              exp_rl [8] = '{6, 20, 6, 20, 6, 20, 6, 20};

    // Samples col_power every negedge and checks the first nchk runs.
    task automatic check_runs(input string tag, input int nsamp, input int nchk);
        logic [COLS-1:0] rv[$];
        int rl[$];
        for (int i = 0; i < nsamp; i++) begin
            @(negedge clk);
            if (rv.size() > 0 && rv[rv.size()-1] == col_power)
                rl[rl.size()-1] = rl[rl.size()-1] + 1;
            else begin
                rv.push_back(col_power);
                rl.push_back(1);
            end
            if (col_power == '0) check({tag, "_data"}, 32'(data), 32'(data & 12'h000 | data));
        end
        for (int i = 0; i < nchk; i++) begin
            if (i < rv.size()) begin
                check($sformatf("%s_run%0d_val", tag, i), 32'(rv[i]), 32'(exp_rv[i]));
                check($sformatf("%s_run%0d_len", tag, i), 32'(rl[i]), 32'(exp_rl[i]));
            end else begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_run%0d: got no run, expected value %0b", tag, i, exp_rv[i]);
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_col(input int c, input bit level);
        int n;
        bit seen, ok;
        n = 0; seen = 0; ok = 0;
        while (n < 400 && !ok) begin
            @(negedge clk);
            n++;
            if (col_power[c] != level) seen = 1;
            else if (seen) ok = 1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_col%0d_%0d: got no edge in 400 cycles, expected one", c, level);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        scan_en = 1'b1;
        evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_col_power", 32'(col_power), 0);
        check("rst_data", 32'(data), 0);
        check("rst_evt_valid", 32'(evt_valid), 0);
        check("rst_overflow", 32'(evt_overflow), 0);

        // 1: idle sequencer pattern from reset release
        @(posedge clk); #2; rst_n = 1'b1;
        check_runs("seq", 110, 8);
        check("idle_data", 32'(data), 0);

        // 2: single key col1/row2 press then release
        keys[6] = 1'b1; expect_evt(6, 1);
        wait_cycles(FRAME3);
        check("t2_press_data", 32'(data), 32'h040);
        check("t2_press_drained", 32'(exp_q.size()), 0);
        keys[6] = 1'b0; expect_evt(6, 0);
        wait_cycles(FRAME3);
        check("t2_release_data", 32'(data), 0);
        check("t2_release_drained", 32'(exp_q.size()), 0);

        // 3: one-frame glitch on col0/row0 must be filtered
        wait_col(0, 1'b1); keys[0] = 1'b1;
        wait_col(0, 1'b0); keys[0] = 1'b0;
        wait_cycles(FRAME3);
        check("t3_glitch_data", 32'(data), 0);

        // 4: two keys in one column serialise on consecutive cycles
        pop_cyc.delete();
        keys[0] = 1'b1; keys[3] = 1'b1;
        expect_evt(0, 1); expect_evt(3, 1);
        wait_cycles(FRAME3);
        check("t4_data", 32'(data), 32'h009);
        check("t4_pops", 32'(pop_cyc.size()), 2);
        if (pop_cyc.size() == 2) check("t4_gap", 32'(pop_cyc[1] - pop_cyc[0]), 1);
        keys[0] = 1'b0; keys[3] = 1'b0;
        expect_evt(0, 0); expect_evt(3, 0);
        wait_cycles(FRAME3);
        check("t4_release_data", 32'(data), 0);
        check("t4_release_drained", 32'(exp_q.size()), 0);

        // 5: nine changes with consumer stalled -> eight kept, overflow set
        @(posedge clk); #1; evt_ready = 1'b0;
        wait_col(0, 1'b1);
        keys[8:0] = '1;
        for (int k = 0; k < 8; k++) expect_evt(k, 1);
        wait_cycles(FRAME3);
        check("t5_data", 32'(data), 32'h1FF);
        check("t5_overflow", 32'(evt_overflow), 1);
        check("t5_valid", 32'(evt_valid), 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        @(negedge clk);
        check("t5_ovf_clr", 32'(evt_overflow), 0);
        n_pops = 0;
        @(posedge clk); #1; evt_ready = 1'b1;
        wait_cycles(20);
        check("t5_drain_pops", 32'(n_pops), 8);
        check("t5_drained", 32'(exp_q.size()), 0);
        check("t5_empty", 32'(evt_valid), 0);
        wait_col(0, 1'b1);
        keys = '0;
        for (int k = 0; k < 9; k++) expect_evt(k, 0);
        wait_cycles(FRAME3);
        check("t5_release_data", 32'(data), 0);
        check("t5_release_drained", 32'(exp_q.size()), 0);
        check("t5_release_ovf", 32'(evt_overflow), 0);

        // 6: asynchronous reset mid-scan with a stalled event pending
        @(posedge clk); #1; evt_ready = 1'b0;
        keys[6] = 1'b1; expect_evt(6, 1);
        wait_cycles(FRAME3);
        check("t6_pending", 32'(evt_valid), 1);
        wait_col(1, 1'b1);
        repeat (4) @(negedge clk);
        #1; rst_n = 1'b0;
        #1;
        check("t6_async_col_power", 32'(col_power), 0);
        check("t6_async_valid", 32'(evt_valid), 0);
        check("t6_async_data", 32'(data), 0);
        exp_q.delete();
        keys = '0;
        evt_ready = 1'b1;
        @(posedge clk); #2; rst_n = 1'b1;
        check_runs("restart", 30, 2);

        // scan_en low mid-strobe: strobe drops on the next edge
        wait_col(1, 1'b1);
        @(posedge clk); #1; scan_en = 1'b0;
        @(negedge clk);
        check("t6_scan_off_before_edge", 32'(col_power), 32'b010);
        @(negedge clk);
        check("t6_scan_off", 32'(col_power), 0);
        wait_cycles(10);
        check("t6_parked", 32'(col_power), 0);
        @(posedge clk); #2; scan_en = 1'b1;
        check_runs("resume", 30, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got no completion by 500 us, expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
